// File: rtl/tt_sweep_pkg.sv
// tt_sweep_pkg: shared types and constants for the truth-table sweeper.
//   sweep_state_t   : sweeper FSM states (IDLE, SETTLE, SAMPLE, DONE)
//   NUM_VEC         : number of input vectors of the 3-input gate
//   SIG_W           : width of the truth-table signature
//   SAMPLES_PER_VEC : samples taken per vector (3 when TT_SWEEP_VOTE_EN is
//                     defined, otherwise 1)
//   maj3()          : 2-of-3 majority helper
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } sweep_state_t;

  localparam int NUM_VEC = 8;
  localparam int SIG_W   = 8;

`ifdef TT_SWEEP_VOTE_EN
  localparam int SAMPLES_PER_VEC = 3;
`else
  localparam int SAMPLES_PER_VEC = 1;
`endif

  // 2-of-3 majority of three sampled bits.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// truth_table_sweeper_if: control, result and gate-side signals of the sweeper.
//   start/expected    : sweep request and golden signature (master -> slave)
//   dut_out           : output of the gate under test (master -> slave)
//   in1/in2/in3       : gate input vector, in1 = MSB (slave -> master)
//   busy/done         : sweep in progress / one-cycle completion pulse
//   table_out/match   : captured signature and comparison result
interface truth_table_sweeper_if;
  import tt_sweep_pkg::*;

  logic             start;
  logic [SIG_W-1:0] expected;
  logic             dut_out;
  logic             in1;
  logic             in2;
  logic             in3;
  logic             busy;
  logic             done;
  logic [SIG_W-1:0] table_out;
  logic             match;

  modport master (
    output start, expected, dut_out,
    input  in1, in2, in3, busy, done, table_out, match
  );

  modport slave (
    input  start, expected, dut_out,
    output in1, in2, in3, busy, done, table_out, match
  );

endinterface

// File: rtl/tt_vote3.sv
// tt_vote3: keeps the two previous gate samples of the current vector and
// outputs the 2-of-3 majority of those plus the sample presented this cycle,
// so the voted bit is ready on the third sample edge.
// Compiled only when TT_SWEEP_VOTE_EN is defined.
//   clk, rst : clock, asynchronous active-high reset
//   shift_en : capture din on this edge (high in SAMPLE)
//   din      : gate output sample
//   maj      : majority of {stored[1], stored[0], din}
`ifdef TT_SWEEP_VOTE_EN
module tt_vote3
  import tt_sweep_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic shift_en,
  input  logic din,
  output logic maj
);

  logic [1:0] hist_r;

  // Sample history shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_r <= 2'b00;
    end else if (shift_en) begin
      hist_r <= {hist_r[0], din};
    end else begin
      hist_r <= hist_r;
    end
  end

  assign maj = maj3(hist_r[1], hist_r[0], din);

endmodule
`endif

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks a 3-input gate through vectors 000..111, waits
// SETTLE_CYCLES per vector, samples the gate output and assembles an 8-bit
// signature (idx 0 in the MSB) which is compared with a latched golden value.
// Optional feature macro: TT_SWEEP_VOTE_EN (3 samples per vector, majority).
//   clk, rst : clock, asynchronous active-high reset
//   bus      : truth_table_sweeper_if.slave (start, expected, dut_out,
//              in1..in3, busy, done, table_out, match)
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  truth_table_sweeper_if.slave   bus
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [1:0] SAMPLE_LAST = 2'(SAMPLES_PER_VEC - 1);
  localparam logic [2:0] LAST_IDX    = 3'(NUM_VEC - 1);

  sweep_state_t     state_r;
  logic [2:0]       idx_r;
  logic [7:0]       settle_cnt_r;
  logic [1:0]       samp_cnt_r;
  logic [SIG_W-1:0] work_r;
  logic [SIG_W-1:0] expected_r;
  logic [SIG_W-1:0] table_r;
  logic [2:0]       vec_r;
  logic             busy_r;
  logic             done_r;
  logic             match_r;

  logic             sample_bit_s;
  logic [2:0]       bit_pos_s;
  logic [SIG_W-1:0] next_work_s;

`ifdef TT_SWEEP_VOTE_EN
  logic shift_en_s;
  assign shift_en_s = (state_r == SAMPLE);

  tt_vote3 u_vote3 (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en_s),
    .din      (bus.dut_out),
    .maj      (sample_bit_s)
  );
`else
  assign sample_bit_s = bus.dut_out;
`endif

  // idx 0 lands in the MSB of the signature.
  assign bit_pos_s = 3'd7 - idx_r;

  // Working signature with the current vector's bit merged in; used on the
  // last sample edge so DONE already sees the complete signature.
  always_comb begin
    next_work_s            = work_r;
    next_work_s[bit_pos_s] = sample_bit_s;
  end

  // Sweep FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      idx_r        <= 3'd0;
      settle_cnt_r <= 8'd0;
      samp_cnt_r   <= 2'd0;
      work_r       <= '0;
      expected_r   <= '0;
      table_r      <= '0;
      vec_r        <= 3'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      match_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            expected_r   <= bus.expected;
            work_r       <= '0;
            match_r      <= 1'b0;
            idx_r        <= 3'd0;
            vec_r        <= 3'd0;
            settle_cnt_r <= 8'd0;
            samp_cnt_r   <= 2'd0;
            busy_r       <= 1'b1;
            state_r      <= SETTLE;
          end else begin
            state_r <= IDLE;
          end
        end
        SETTLE: begin
          if (settle_cnt_r == SETTLE_LAST) begin
            samp_cnt_r <= 2'd0;
            state_r    <= SAMPLE;
          end else begin
            settle_cnt_r <= settle_cnt_r + 8'd1;
          end
        end
        SAMPLE: begin
          if (samp_cnt_r == SAMPLE_LAST) begin
            work_r <= next_work_s;
            if (idx_r == LAST_IDX) begin
              // table_out/match update on the edge that raises done.
              table_r <= next_work_s;
              match_r <= (next_work_s == expected_r);
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              vec_r   <= 3'd0;
              state_r <= DONE;
            end else begin
              idx_r        <= idx_r + 3'd1;
              vec_r        <= idx_r + 3'd1;
              settle_cnt_r <= 8'd0;
              state_r      <= SETTLE;
            end
          end else begin
            samp_cnt_r <= samp_cnt_r + 2'd1;
          end
        end
        DONE: begin
          // start is ignored here; it is accepted on the next cycle in IDLE.
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          vec_r   <= 3'd0;
        end
      endcase
    end
  end

  assign bus.in1       = vec_r[2];
  assign bus.in2       = vec_r[1];
  assign bus.in3       = vec_r[0];
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.table_out = table_r;
  assign bus.match     = match_r;

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequential stimulus-and-capture stage that sits directly upstream of a 3-input combinational logic gate (in1, in2, in3 → out).
- Drives the gate's inputs through all eight combinations, 000 to 111.
- Waits a programmable settle time per vector, then samples the gate output.
- Assembles the 8-bit truth-table signature in the codebase's hex-name convention (e.g. 0xDD) and compares it against an expected value.
- Used for characterization and self-check of gate netlists.

## Interface
Parameters:
- SETTLE_CYCLES, default 2, cycles each vector is held before sampling begins; legal range 1..255.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a sweep; accepted only in IDLE.
- expected  input  8  golden signature; latched when start is accepted.
- dut_out  input  1  output of the gate under test.
- in1  output  1  gate input, MSB of the vector index.
- in2  output  1  gate input, middle bit of the vector index.
- in3  output  1  gate input, LSB of the vector index.
- busy  output  1  high from start acceptance until done.
- done  output  1  one-cycle pulse when the signature is final.
- table_out  output  8  captured signature.
- match  output  1  table_out == latched expected; valid from done until the next start.

## Operation
- Vector index idx is 3 bits; {in1,in2,in3} = idx while sweeping.
- Signature bit mapping: table_out[7-idx] holds the sample taken for idx, so idx 000 lands in the MSB.
  - Example: a gate giving 1,1,0,1,1,1,0,1 for idx 0..7 yields 0xDD.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE → SETTLE on start.
  - Latch expected.
  - Clear the working shift register and match.
  - Set idx=0 and settle counter=0.
- SETTLE: hold idx for SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE: lasts S cycles (S=1, or 3 with voting; see Configuration). dut_out is registered on each SAMPLE edge.
  - After the last sample: write the bit.
  - If idx==7, go to DONE.
  - Otherwise increment idx, reset the settle counter, and go to SETTLE.
- DONE, one cycle:
  - done=1.
  - table_out ← working register.
  - match ← (working register == latched expected).
  - Next state is IDLE.
- In IDLE and DONE, {in1,in2,in3}=000. busy=1 in SETTLE and SAMPLE only.
- start while busy or in DONE is ignored; there is no queuing.
- table_out and match hold their values through IDLE until the next DONE. A new start clears match to 0 immediately.
- idx never wraps mid-sweep; termination happens at idx==7.

## Timing
- Reset values: in1=in2=in3=0, busy=0, done=0, table_out=8'h00, match=0, state IDLE.
- Reset asserted mid-sweep: all of the above take effect asynchronously and the partial signature is discarded.
- start sampled at edge E0. busy and the idx=0 vector are visible after E0.
- Each vector is held for SETTLE_CYCLES+S cycles.
- done is high during cycle 8·(SETTLE_CYCLES+S)+1 after E0.
  - Defaults, without voting: 25.
- table_out and match change on the same edge that raises done.
- start coincident with done is ignored. It is accepted the following cycle, in IDLE.

## Configuration
- TT_SWEEP_VOTE_EN defined:
  - S=3; dut_out is sampled on three consecutive SAMPLE cycles.
  - The stored bit is the 2-of-3 majority.
  - Per-vector time is SETTLE_CYCLES+3.
- TT_SWEEP_VOTE_EN undefined:
  - S=1; a single sample is stored directly.
  - No voter logic is instantiated.

## Structure
- Shared package tt_sweep_pkg holds:
  - the state enum (IDLE, SETTLE, SAMPLE, DONE);
  - NUM_VEC=8;
  - the signature width constant 8;
  - SAMPLES_PER_VEC, derived from TT_SWEEP_VOTE_EN.
- One sub-module, tt_vote3: 3-sample shift register with majority output. It is compiled only under TT_SWEEP_VOTE_EN.

## Test plan
- Gate model for truth table 0xDD, SETTLE_CYCLES=2, expected=8'hDD, start pulsed.
  - Expected: in vectors 000..111 each held 3 cycles; done at cycle 25; table_out=8'hDD; match=1.
- Same model with expected=8'hDE → table_out=8'hDD, match=0.
- start re-pulsed at cycles 5 and 12 of a sweep → ignored; done still occurs at cycle 25 only, once.
- rst asserted at cycle 10 of a sweep, after a previous result of 8'hDD.
  - Expected: immediately in1..3=0, busy=0, table_out=8'h00; a new sweep then completes normally.
- With TT_SWEEP_VOTE_EN, dut_out glitched low on one of the three samples for idx 011 (true value 1).
  - Expected: table_out=8'hDD, match=1, done at cycle 41.
- Constant-0 gate with expected=8'h00 → table_out=8'h00, match=1. Constant-1 gate → table_out=8'hFF.
